register_file: RTL and testbench

Parametrised MIPS general-purpose register file: DEPTH registers of WORD_LENGTH bits with one synchronous write port and two asynchronous read ports. It extends the single enabled flip-flop register to an addressed bank with these additions:
- hardwired zero register;
- programmable reset values for the stack and global pointers;
- optional write-to-read bypass.

It sits between the instruction decode stage and the ALU in the MIPS datapath.

---
 rtl/register_file.sv | 84 ++++++++
 tb/tb_register_file.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/register_file.sv
// MIPS general-purpose register file: one synchronous write port, two
// combinational read ports, hardwired zero register, programmable SP/GP
// reset values and optional same-cycle write-to-read forwarding.
module register_file #(
    parameter int unsigned WORD_LENGTH = 32,
    parameter int unsigned ADDR_WIDTH  = 5,
    parameter int unsigned DEPTH       = 2 ** ADDR_WIDTH,
    parameter int unsigned SP_INDEX    = 29,
    parameter logic [31:0] SP_RESET    = 32'h1001_03FC,
    parameter int unsigned GP_INDEX    = 28,
    parameter logic [31:0] GP_RESET    = 32'h1000_8000,
    parameter bit          BYPASS      = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   Reg_Write,
    input  logic [ADDR_WIDTH-1:0]  Write_Register,
    input  logic [WORD_LENGTH-1:0] Write_Data,
    input  logic [ADDR_WIDTH-1:0]  Read_Register1,
    input  logic [ADDR_WIDTH-1:0]  Read_Register2,
    output logic [WORD_LENGTH-1:0] Read_Data1,
    output logic [WORD_LENGTH-1:0] Read_Data2
);

    // Reset values truncated (or zero-extended) to the word width.
    localparam logic [WORD_LENGTH-1:0] SpResetVal = WORD_LENGTH'(SP_RESET);
    localparam logic [WORD_LENGTH-1:0] GpResetVal = WORD_LENGTH'(GP_RESET);

    // Register 0 has no storage: the bank starts at index 1. Out-of-range
    // SP/GP indices simply never match any stored register.
    logic [WORD_LENGTH-1:0] regs_q [1:DEPTH-1];

    logic [ADDR_WIDTH-1:0]  rd_addr [2];
    logic [WORD_LENGTH-1:0] rd_data [2];
    logic                   bypass_en;

    function automatic logic [WORD_LENGTH-1:0] reset_value(input int unsigned idx);
        if (idx == SP_INDEX) begin
            return SpResetVal;
        end else if (idx == GP_INDEX) begin
            return GpResetVal;
        end else begin
            return '0;
        end
    endfunction

    assign rd_addr[0] = Read_Register1;
    assign rd_addr[1] = Read_Register2;

    // Forwarding is disabled while reset is high so reads show stored contents.
    assign bypass_en = BYPASS && Reg_Write && !reset;

    // Storage update: reset wins over a write presented on the same edge;
    // writes to address 0 or beyond DEPTH match no register and are dropped.
    always_ff @(posedge clk) begin
        for (int i = 1; i < int'(DEPTH); i++) begin
            if (reset) begin
                regs_q[i] <= reset_value(i);
            end else if (Reg_Write && (Write_Register == ADDR_WIDTH'(i))) begin
                regs_q[i] <= Write_Data;
            end
        end
    end

    // Read decode per port: unmatched addresses (0 or >= DEPTH) return zero.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rd_data[p] = '0;
            for (int i = 1; i < int'(DEPTH); i++) begin
                if (rd_addr[p] == ADDR_WIDTH'(i)) begin
                    if (bypass_en && (Write_Register == ADDR_WIDTH'(i))) begin
                        rd_data[p] = Write_Data;
                    end else begin
                        rd_data[p] = regs_q[i];
                    end
                end
            end
        end
    end

    assign Read_Data1 = rd_data[0];
    assign Read_Data2 = rd_data[1];

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: a forwarding and a non-forwarding
// 32x32 instance share stimulus; a 16-bit, 12-deep instance covers the
// reduced-depth configuration.
module tb_register_file;

    logic        clk = 1'b0;
    logic        reset;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rd1_b, rd2_b, rd1_n, rd2_n;

    logic        s_reset;
    logic        s_we;
    logic [3:0]  s_wa;
    logic [15:0] s_wd;
    logic [3:0]  s_ra1;
    logic [3:0]  s_ra2;
    logic [15:0] s_rd1, s_rd2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    register_file #(.BYPASS(1'b1)) u_byp (
        .clk(clk), .reset(reset), .Reg_Write(we), .Write_Register(wa), .Write_Data(wd),
        .Read_Register1(ra1), .Read_Register2(ra2), .Read_Data1(rd1_b), .Read_Data2(rd2_b)
    );

    register_file #(.BYPASS(1'b0)) u_nobyp (
        .clk(clk), .reset(reset), .Reg_Write(we), .Write_Register(wa), .Write_Data(wd),
        .Read_Register1(ra1), .Read_Register2(ra2), .Read_Data1(rd1_n), .Read_Data2(rd2_n)
    );

    register_file #(.WORD_LENGTH(16), .ADDR_WIDTH(4), .DEPTH(12)) u_small (
        .clk(clk), .reset(s_reset), .Reg_Write(s_we), .Write_Register(s_wa),
        .Write_Data(s_wd), .Read_Register1(s_ra1), .Read_Register2(s_ra2),
        .Read_Data1(s_rd1), .Read_Data2(s_rd2)
    );

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra1;
        logic [4:0]  ra2;
        logic [31:0] exp1_b;
        logic [31:0] exp2_b;
        logic [31:0] exp1_n;
        logic [31:0] exp2_n;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rst_model(input int a);
        if (a == 29) return 32'h1001_03FC;
        if (a == 28) return 32'h1000_8000;
        return 32'h0;
    endfunction

    initial begin
        // Table: inputs applied after a falling edge, outputs checked before the
        // next rising edge, which then commits any write.
        vecs[0]  = '{1, 8,  32'hDEAD_BEEF, 8,  9,  32'hDEAD_BEEF, 32'h0,
                     32'h0, 32'h0};
        vecs[1]  = '{1, 9,  32'h1234_5678, 8,  9,  32'hDEAD_BEEF, 32'h1234_5678,
                     32'hDEAD_BEEF, 32'h0};
        vecs[2]  = '{0, 0,  32'h0, 8,  9,  32'hDEAD_BEEF, 32'h1234_5678,
                     32'hDEAD_BEEF, 32'h1234_5678};
        vecs[3]  = '{0, 0,  32'h0, 9,  9,  32'h1234_5678, 32'h1234_5678,
                     32'h1234_5678, 32'h1234_5678};
        vecs[4]  = '{1, 0,  32'hFFFF_FFFF, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0};
        vecs[5]  = '{0, 0,  32'h0, 0,  0,  32'h0, 32'h0, 32'h0, 32'h0};
        vecs[6]  = '{1, 5,  32'hA, 5, 29, 32'hA, 32'h1001_03FC, 32'h0, 32'h1001_03FC};
        vecs[7]  = '{1, 5,  32'hB, 5,  5,  32'hB, 32'hB, 32'hA, 32'hA};
        vecs[8]  = '{0, 0,  32'h0, 5, 28, 32'hB, 32'h1000_8000, 32'hB, 32'h1000_8000};
        vecs[9]  = '{1, 29, 32'h77, 29, 8, 32'h77, 32'hDEAD_BEEF,
                     32'h1001_03FC, 32'hDEAD_BEEF};
        vecs[10] = '{0, 0,  32'h0, 29, 29, 32'h77, 32'h77, 32'h77, 32'h77};
        vecs[11] = '{0, 5,  32'hC, 5,  5,  32'hB, 32'hB, 32'hB, 32'hB};

        reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0;
        s_reset = 1'b1; s_we = 1'b0; s_wa = '0; s_wd = '0; s_ra1 = '0; s_ra2 = '0;
        @(negedge clk);
        reset = 1'b0;
        s_reset = 1'b0;

        // Reset contents on every address of both 32-bit instances.
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            check($sformatf("rst_b_p1[%0d]", a), rd1_b, rst_model(a));
            check($sformatf("rst_b_p2[%0d]", 31 - a), rd2_b, rst_model(31 - a));
            check($sformatf("rst_n_p1[%0d]", a), rd1_n, rst_model(a));
            check($sformatf("rst_n_p2[%0d]", 31 - a), rd2_n, rst_model(31 - a));
        end

        for (int v = 0; v < 12; v++) begin
            @(negedge clk);
            we = vecs[v].we; wa = vecs[v].wa; wd = vecs[v].wd;
            ra1 = vecs[v].ra1; ra2 = vecs[v].ra2;
            #1;
            check($sformatf("vec%0d_b_p1", v), rd1_b, vecs[v].exp1_b);
            check($sformatf("vec%0d_b_p2", v), rd2_b, vecs[v].exp2_b);
            check($sformatf("vec%0d_n_p1", v), rd1_n, vecs[v].exp1_n);
            check($sformatf("vec%0d_n_p2", v), rd2_n, vecs[v].exp2_n);
        end

        // Give reg 3 a known value, then collide a write with reset.
        @(negedge clk);
        we = 1'b1; wa = 5'd3; wd = 32'h33; ra1 = 5'd3; ra2 = 5'd3;
        @(negedge clk);
        reset = 1'b1; we = 1'b1; wa = 5'd3; wd = 32'h55; ra1 = 5'd3; ra2 = 5'd29;
        #1;
        // Forwarding is suppressed during reset: stored contents are visible.
        check("rstcyc_b_r3", rd1_b, 32'h33);
        check("rstcyc_b_r29", rd2_b, 32'h77);
        check("rstcyc_n_r3", rd1_n, 32'h33);
        @(negedge clk);
        reset = 1'b0; we = 1'b0; ra1 = 5'd3; ra2 = 5'd29;
        #1;
        check("postrst_b_r3", rd1_b, 32'h0);
        check("postrst_b_r29", rd2_b, 32'h1001_03FC);
        check("postrst_n_r3", rd1_n, 32'h0);
        check("postrst_n_r29", rd2_n, 32'h1001_03FC);
        ra1 = 5'd8; ra2 = 5'd5;
        #1;
        check("postrst_b_r8", rd1_b, 32'h0);
        check("postrst_b_r5", rd2_b, 32'h0);

        // Reduced configuration: 16-bit words, 12 registers.
        for (int a = 0; a < 16; a++) begin
            s_ra1 = 4'(a);
            s_ra2 = 4'(15 - a);
            #1;
            check($sformatf("small_rst_p1[%0d]", a), 32'(s_rd1), 32'h0);
            check($sformatf("small_rst_p2[%0d]", 15 - a), 32'(s_rd2), 32'h0);
        end
        @(negedge clk);
        s_we = 1'b1; s_wa = 4'd11; s_wd = 16'hBEEF; s_ra1 = 4'd11; s_ra2 = 4'd10;
        #1;
        check("small_byp_r11", 32'(s_rd1), 32'hBEEF);
        check("small_r10", 32'(s_rd2), 32'h0);
        @(negedge clk);
        s_we = 1'b1; s_wa = 4'd13; s_wd = 16'h1234; s_ra1 = 4'd13; s_ra2 = 4'd11;
        #1;
        check("small_byp_r13", 32'(s_rd1), 32'h0);
        check("small_r11", 32'(s_rd2), 32'hBEEF);
        @(negedge clk);
        s_we = 1'b0; s_ra1 = 4'd13; s_ra2 = 4'd11;
        #1;
        check("small_post_r13", 32'(s_rd1), 32'h0);
        check("small_post_r11", 32'(s_rd2), 32'hBEEF);
        s_ra1 = 4'd1; s_ra2 = 4'd12;
        #1;
        check("small_post_r1", 32'(s_rd1), 32'h0);
        check("small_post_r12", 32'(s_rd2), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
